mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the core's two memory initiators: the LSU single-bus read/write port and the IFU fetch port.
- Holds a doubleword-organised storage array and arbitrates one access at a time between the two ports, LSU first.
- Returns each response after a programmable latency.
- Sits outside the core, wired port-for-port to the core's memory interface; used in simulation and FPGA bring-up.

Parameters:
- DEPTH, 65536: number of 64-bit doublewords in the array.
- BASE_ADDR, 64'h8000_0000: byte address mapped to array index 0.
- LATENCY, 1: cycles from request acceptance to response-valid; range 1..15.

Ports:
- core_clk  in  1  clock.
- core_rst_n  in  1  reset, asynchronous assert, active-low.
- lsu_memory_data  in  64  LSU write data, LSB-aligned.
- lsu_memory_addr  in  64  LSU byte address.
- lsu_memory_dir  in  1  0 = read, 1 = write.
- lsu_memory_valid  in  1  LSU request valid.
- lsu_memory_width  in  4  access size in bytes: 1, 2, 4 or 8.
- memory_lsu_ready  out  1  responder can accept an LSU request.
- memory_lsu_data  out  64  LSU read data, zero-extended.
- memory_lsu_valid  out  1  LSU response valid, one-cycle pulse; also pulses for writes.
- ifu_memory_addr  in  64  fetch byte address.
- ifu_memory_valid  in  1  fetch request valid.
- memory_ifu_data  out  32  fetched instruction.
- memory_ifu_valid  out  1  fetch response valid, one-cycle pulse.
- mem_err  out  1  one-cycle pulse alongside a response that was out-of-range, misaligned or had an illegal width.

Behaviour:
Reset:
- Every output is 0 except memory_lsu_ready, which is 1.
- State returns to IDLE and the latency counter clears.
- Array contents are not reset.

State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - An LSU request is accepted when lsu_memory_valid && memory_lsu_ready.
  - Otherwise an IFU request is accepted when ifu_memory_valid.
  - On acceptance, latch owner, addr, dir, width and data, load the counter with LATENCY-1, and drop memory_lsu_ready next cycle.
  - LATENCY=1 goes directly to RESP.
- WAIT: decrement the counter; go to RESP when it reaches 0.
- RESP:
  - Perform the array access.
  - Pulse the owner's valid output for exactly one cycle with its data.
  - Return to IDLE; memory_lsu_ready is high again in the following cycle.

Latency and throughput:
- Response-valid asserts exactly LATENCY cycles after the accept edge.
- Back-to-back throughput is one access per LATENCY+1 cycles.

Arbitration and holding:
- LSU has strict priority over IFU.
- An IFU request that arrives while busy is not dropped: the IFU holds ifu_memory_valid until memory_ifu_valid.
- Inputs that change after acceptance are ignored.

Address and data rules:
- Index = (addr - BASE_ADDR) >> 3.
- Byte offset = addr[2:0].
- LSU read: doubleword >> (offset*8), masked to width bytes.
- LSU write: updates only bytes offset .. offset+width-1; byte-enable mask = ((1<<width)-1) << offset.
- IFU read: returns the word selected by addr[2].

Error conditions:
- Index >= DEPTH, or addr < BASE_ADDR:
  - read data is 0, writes are dropped, mem_err pulses.
- offset+width > 8 (doubleword crossing), width not in {1,2,4,8}, or IFU addr[1:0] != 0:
  - treated as error: no write, read data 0, mem_err pulses.

Reset mid-operation:
- Any in-flight access is abandoned and no response is issued.
- A write not yet at RESP is not performed.

Optional Feature:
MEM_RAND_LATENCY_EN
- Defined:
  - A 16-bit LFSR, seeded with 16'hACE1 at reset and advanced every cycle, adds 0..3 extra WAIT cycles per access (LFSR[1:0] sampled at acceptance).
  - Used to stress the core's valid/ready handling.
- Undefined: latency is exactly LATENCY.

Decomposition:
- Shared package/include holds:
  - state encodings MEM_IDLE, MEM_WAIT, MEM_RESP;
  - owner encodings OWN_LSU, OWN_IFU;
  - MEM_BASE_ADDR default;
  - width codes.
- One sub-module, mem_byte_lane, forms the 8-bit byte-enable mask and the shifted read/write data from offset and width.
- The array stays in the top level.

Test Plan:
1. LATENCY=1, LSU write addr 0x8000_0010, width 8, data 0x1122334455667788, then read same address → memory_lsu_valid 1 cycle after each accept; read data 0x1122334455667788; mem_err 0.
2. Byte/half writes: write 0xAB to 0x8000_0013 with width 1, then read 0x8000_0010 with width 8 → 0x11223344AB667788; read 0x8000_0012 with width 2 → 0x0000_0000_0000_AB66.
3. IFU fetch 0x8000_0014 concurrent with LSU read 0x8000_0000, both valid in the same cycle → LSU served first; memory_ifu_valid LATENCY+1 cycles after LSU response-valid, data 0x11223344.
4. LSU read 0x7FFF_FFF8 and write 0x8000_0006 with width 4 → mem_err pulses with each response; read data 0; array unchanged.
5. LATENCY=3, core_rst_n asserted in WAIT of a write to 0x8000_0020 → no valid pulse; memory_lsu_ready=1 after reset; a later read of 0x8000_0020 returns the prior contents.
6. With MEM_RAND_LATENCY_EN, 200 random LSU/IFU accesses against a scoreboard → every response between LATENCY and LATENCY+3 cycles after accept; all data matches.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: FSM states, request owners, width codes.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IFU = 1'b1
  } mem_owner_e;

  localparam logic [63:0] MEM_BASE_ADDR = 64'h8000_0000;

  localparam logic [3:0] WIDTH_B = 4'd1;
  localparam logic [3:0] WIDTH_H = 4'd2;
  localparam logic [3:0] WIDTH_W = 4'd4;
  localparam logic [3:0] WIDTH_D = 4'd8;

  // Wide enough for LATENCY-1 (max 14) plus up to 3 random extra cycles.
  localparam int unsigned CNT_W = 5;

  typedef struct packed {
    mem_owner_e  owner;
    logic [63:0] addr;
    logic        dir;
    logic [3:0]  width;
    logic [63:0] data;
  } mem_req_t;

  function automatic logic width_legal(input logic [3:0] w);
    return (w == WIDTH_B) || (w == WIDTH_H) || (w == WIDTH_W) || (w == WIDTH_D);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: byte-enable mask, write-data shift and read-data extract from offset/width.
module mem_byte_lane
  import mem_responder_pkg::*;
(
  input  logic [2:0]  i_offset,
  input  logic [3:0]  i_width,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdword,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata,
  output logic        o_err
);

  logic [4:0]  w_end;
  logic [7:0]  w_len_mask;
  logic [63:0] w_mask;

  always_comb begin
    w_end      = 5'(i_offset) + 5'(i_width);
    o_err      = !width_legal(i_width) || (w_end > 5'd8);
    w_len_mask = 8'((16'(1) << i_width) - 16'(1));
    o_be       = o_err ? 8'h00 : (w_len_mask << i_offset);
    w_mask     = '0;
    for (int i = 0; i < 8; i++) begin
      w_mask[i*8 +: 8] = {8{w_len_mask[i]}};
    end
    o_rdata = (i_rdword >> {i_offset, 3'b000}) & w_mask;
    o_wdata = i_wdata << {i_offset, 3'b000};
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the core's LSU and IFU ports; one access at a time, LSU first.
// Define MEM_RAND_LATENCY_EN to add 0..3 LFSR-chosen extra wait cycles per access.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 65536,
  parameter logic [63:0] BASE_ADDR = MEM_BASE_ADDR,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic [63:0] lsu_memory_data,
  input  logic [63:0] lsu_memory_addr,
  input  logic        lsu_memory_dir,
  input  logic        lsu_memory_valid,
  input  logic [3:0]  lsu_memory_width,
  output logic        memory_lsu_ready,
  output logic [63:0] memory_lsu_data,
  output logic        memory_lsu_valid,
  input  logic [63:0] ifu_memory_addr,
  input  logic        ifu_memory_valid,
  output logic [31:0] memory_ifu_data,
  output logic        memory_ifu_valid,
  output logic        mem_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]      r_mem [DEPTH];
  mem_state_e       r_state;
  mem_req_t         r_req;
  logic [CNT_W-1:0] r_cnt;

  mem_req_t         w_lsu_req;
  mem_req_t         w_ifu_req;
  logic             w_acc_lsu;
  logic             w_acc_ifu;
  logic [1:0]       w_extra;
  logic [CNT_W-1:0] w_load;
  logic [63:0]      w_idx;
  logic [IDX_W-1:0] w_mem_idx;
  logic             w_range_err;
  logic             w_align_err;
  logic             w_lane_err;
  logic             w_err;
  logic [63:0]      w_rdword;
  logic [63:0]      w_rdata;
  logic [63:0]      w_wdata_sh;
  logic [7:0]       w_be;
  logic [63:0]      w_bemask;
  logic [63:0]      w_merged;
  logic             w_wr_en;

`ifdef MEM_RAND_LATENCY_EN
  logic [15:0] r_lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) for latency jitter.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) r_lfsr <= 16'hACE1;
    else             r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_extra = r_lfsr[1:0];
`else
  assign w_extra = 2'b00;
`endif

  always_comb begin
    w_lsu_req.owner = OWN_LSU;
    w_lsu_req.addr  = lsu_memory_addr;
    w_lsu_req.dir   = lsu_memory_dir;
    w_lsu_req.width = lsu_memory_width;
    w_lsu_req.data  = lsu_memory_data;
    w_ifu_req.owner = OWN_IFU;
    w_ifu_req.addr  = ifu_memory_addr;
    w_ifu_req.dir   = 1'b0;
    w_ifu_req.width = WIDTH_W;
    w_ifu_req.data  = '0;
    w_acc_lsu = (r_state == MEM_IDLE) && lsu_memory_valid && memory_lsu_ready;
    w_acc_ifu = (r_state == MEM_IDLE) && !w_acc_lsu && ifu_memory_valid;
    w_load    = CNT_W'(LATENCY - 1) + CNT_W'(w_extra);
  end

  // Address decode and error classification for the latched request.
  always_comb begin
    w_idx       = (r_req.addr - BASE_ADDR) >> 3;
    w_range_err = (r_req.addr < BASE_ADDR) || (w_idx >= 64'(DEPTH));
    w_align_err = (r_req.owner == OWN_IFU) && (r_req.addr[1:0] != 2'b00);
    w_mem_idx   = w_idx[IDX_W-1:0];
    w_rdword    = r_mem[w_mem_idx];
  end

  mem_byte_lane u_lane (
    .i_offset (r_req.addr[2:0]),
    .i_width  (r_req.width),
    .i_wdata  (r_req.data),
    .i_rdword (w_rdword),
    .o_be     (w_be),
    .o_wdata  (w_wdata_sh),
    .o_rdata  (w_rdata),
    .o_err    (w_lane_err)
  );

  always_comb begin
    w_err    = w_range_err || w_align_err || w_lane_err;
    w_bemask = '0;
    for (int i = 0; i < 8; i++) begin
      w_bemask[i*8 +: 8] = {8{w_be[i]}};
    end
    w_merged = (w_rdword & ~w_bemask) | (w_wdata_sh & w_bemask);
    w_wr_en  = (r_state == MEM_RESP) && (r_req.owner == OWN_LSU) && r_req.dir && !w_err;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge core_clk) begin
    if (w_wr_en) r_mem[w_mem_idx] <= w_merged;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_state          <= MEM_IDLE;
      r_req            <= '0;
      r_cnt            <= '0;
      memory_lsu_ready <= 1'b1;
      memory_lsu_data  <= '0;
      memory_lsu_valid <= 1'b0;
      memory_ifu_data  <= '0;
      memory_ifu_valid <= 1'b0;
      mem_err          <= 1'b0;
    end else begin
      memory_lsu_valid <= 1'b0;
      memory_ifu_valid <= 1'b0;
      mem_err          <= 1'b0;
      case (r_state)
        MEM_IDLE: begin
          if (w_acc_lsu || w_acc_ifu) begin
            r_req            <= w_acc_lsu ? w_lsu_req : w_ifu_req;
            r_cnt            <= w_load;
            r_state          <= (w_load == '0) ? MEM_RESP : MEM_WAIT;
            memory_lsu_ready <= 1'b0;
          end
        end
        MEM_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= MEM_RESP;
        end
        MEM_RESP: begin
          if (r_req.owner == OWN_LSU) begin
            memory_lsu_valid <= 1'b1;
            memory_lsu_data  <= w_err ? 64'd0 : w_rdata;
          end else begin
            memory_ifu_valid <= 1'b1;
            memory_ifu_data  <= w_err ? 32'd0 : w_rdata[31:0];
          end
          mem_err          <= w_err;
          memory_lsu_ready <= 1'b1;
          r_state          <= MEM_IDLE;
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic vs a byte-level model.
module tb_mem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int unsigned DEPTH = 65536;
`ifdef MEM_RAND_LATENCY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel;
  logic [63:0] lsu_data, lsu_addr, ifu_addr;
  logic        lsu_dir, lsu_valid, ifu_valid;
  logic [3:0]  lsu_width;

  logic a_ready, a_lvalid, a_ivalid, a_err;
  logic b_ready, b_lvalid, b_ivalid, b_err;
  logic [63:0] a_ldata, b_ldata;
  logic [31:0] a_idata, b_idata;

  // sel=0 routes traffic to the LATENCY=1 instance, sel=1 to the LATENCY=3 instance
  mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut_l1 (
    .core_clk(clk), .core_rst_n(rst_a),
    .lsu_memory_data(lsu_data), .lsu_memory_addr(lsu_addr), .lsu_memory_dir(lsu_dir),
    .lsu_memory_valid(lsu_valid & ~sel), .lsu_memory_width(lsu_width),
    .memory_lsu_ready(a_ready), .memory_lsu_data(a_ldata), .memory_lsu_valid(a_lvalid),
    .ifu_memory_addr(ifu_addr), .ifu_memory_valid(ifu_valid & ~sel),
    .memory_ifu_data(a_idata), .memory_ifu_valid(a_ivalid), .mem_err(a_err));

  mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_dut_l3 (
    .core_clk(clk), .core_rst_n(rst_b),
    .lsu_memory_data(lsu_data), .lsu_memory_addr(lsu_addr), .lsu_memory_dir(lsu_dir),
    .lsu_memory_valid(lsu_valid & sel), .lsu_memory_width(lsu_width),
    .memory_lsu_ready(b_ready), .memory_lsu_data(b_ldata), .memory_lsu_valid(b_lvalid),
    .ifu_memory_addr(ifu_addr), .ifu_memory_valid(ifu_valid & sel),
    .memory_ifu_data(b_idata), .memory_ifu_valid(b_ivalid), .mem_err(b_err));

  logic        o_ready, o_lvalid, o_ivalid, o_err;
  logic [63:0] o_ldata;
  logic [31:0] o_idata;
  assign o_ready  = sel ? b_ready  : a_ready;
  assign o_lvalid = sel ? b_lvalid : a_lvalid;
  assign o_ivalid = sel ? b_ivalid : a_ivalid;
  assign o_err    = sel ? b_err    : a_err;
  assign o_ldata  = sel ? b_ldata  : a_ldata;
  assign o_idata  = sel ? b_idata  : a_idata;

  int n_vec = 0;
  int n_bad = 0;

  // Byte-addressed model of the LATENCY=1 instance's storage
  logic [7:0] mdl [longint unsigned];

  function automatic bit mdl_err(input bit ifu, input logic [63:0] a, input int w);
    if (a < BASE) return 1'b1;
    if (((a - BASE) >> 3) >= 64'(DEPTH)) return 1'b1;
    if (w != 1 && w != 2 && w != 4 && w != 8) return 1'b1;
    if (int'(a[2:0]) + w > 8) return 1'b1;
    if (ifu && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] mdl_read(input logic [63:0] a, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++)
      if (mdl.exists(a + 64'(i))) r[i*8 +: 8] = mdl[a + 64'(i)];
    return r;
  endfunction

  function automatic void mdl_write(input logic [63:0] a, input int w, input logic [63:0] d);
    for (int i = 0; i < w; i++) mdl[a + 64'(i)] = d[i*8 +: 8];
  endfunction

  // One LSU access; lat counts edges from accept edge to response-valid (99 on timeout)
  task automatic do_lsu(input logic dir, input logic [63:0] a, input int w, input logic [63:0] d,
                        output int lat, output logic [63:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    lsu_dir = dir; lsu_addr = a; lsu_width = 4'(w); lsu_data = d; lsu_valid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (o_ready && n < 50);
    lsu_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    do begin @(posedge clk); #1; lat++; end while (!o_lvalid && lat < 50);
    if (!o_lvalid) lat = 99;
    rd = o_ldata; er = o_err;
  endtask

  task automatic do_ifu(input logic [63:0] a, output int lat, output logic [31:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    ifu_addr = a; ifu_valid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (o_ready && n < 50);
    lat = 0; rd = '0; er = 1'b0;
    do begin @(posedge clk); #1; lat++; end while (!o_ivalid && lat < 50);
    ifu_valid = 1'b0;
    if (!o_ivalid) lat = 99;
    rd = o_idata; er = o_err;
  endtask

  task automatic test_reset(input string tag);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      n_vec++;
      if ({o_ready, o_lvalid, o_ivalid, o_err} !== 4'b1000 || o_ldata !== 64'd0 || o_idata !== 32'd0) begin
        n_bad++;
        $display("FAIL %s[%0d]: ready/lv/iv/err=%b ldata=%h idata=%h, required 1000 and zero data",
                 tag, s, {o_ready, o_lvalid, o_ivalid, o_err}, o_ldata, o_idata);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_fill();
    int lat; logic [63:0] rd, d; logic er;
    sel = 1'b0;
    for (int k = 0; k < 32; k++) begin
      d = {$urandom, $urandom};
      do_lsu(1'b1, BASE + 64'(k * 8), 8, d, lat, rd, er);
      mdl_write(BASE + 64'(k * 8), 8, d);
      n_vec++;
      if (lat < 1 || lat > 1 + EXTRA || er !== 1'b0) begin
        n_bad++; $display("FAIL fill[%0d]: lat=%0d err=%b, required lat 1..%0d err 0", k, lat, er, 1 + EXTRA);
      end
    end
  endtask

  task automatic test_basic();
    int lat; logic [63:0] rd; logic er;
    sel = 1'b0;
    do_lsu(1'b1, 64'h8000_0010, 8, 64'h1122334455667788, lat, rd, er);
    mdl_write(64'h8000_0010, 8, 64'h1122334455667788);
    n_vec++;
    if (lat < 1 || lat > 1 + EXTRA || er !== 1'b0) begin
      n_bad++; $display("FAIL basic_wr: lat=%0d err=%b, required lat 1..%0d err 0", lat, er, 1 + EXTRA);
    end
    do_lsu(1'b0, 64'h8000_0010, 8, 64'd0, lat, rd, er);
    n_vec++;
    if (lat < 1 || lat > 1 + EXTRA || er !== 1'b0 || rd !== 64'h1122334455667788) begin
      n_bad++; $display("FAIL basic_rd: lat=%0d err=%b data=%h, required lat 1 err 0 data 1122334455667788", lat, er, rd);
    end
  endtask

  task automatic test_partial();
    int lat; logic [63:0] rd; logic er;
    sel = 1'b0;
    do_lsu(1'b1, 64'h8000_0013, 1, 64'h0000_0000_0000_00AB, lat, rd, er);
    mdl_write(64'h8000_0013, 1, 64'hAB);
    n_vec++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL byte_wr: err=%b, required 0", er); end
    do_lsu(1'b0, 64'h8000_0010, 8, 64'd0, lat, rd, er);
    n_vec++;
    if (er !== 1'b0 || rd !== 64'h11223344AB667788) begin
      n_bad++; $display("FAIL byte_rd_d: err=%b data=%h, required 0 / 11223344ab667788", er, rd);
    end
    do_lsu(1'b0, 64'h8000_0012, 2, 64'd0, lat, rd, er);
    n_vec++;
    if (er !== 1'b0 || rd !== 64'h0000_0000_0000_AB66) begin
      n_bad++; $display("FAIL half_rd: err=%b data=%h, required 0 / 000000000000ab66", er, rd);
    end
  endtask

  task automatic test_arbitration();
    int t_l = -1, t_i = -1, n = 0;
    bit dropped = 1'b0;
    logic [63:0] exp_l = mdl_read(BASE, 8);
    logic [63:0] got_l = '0;
    logic [31:0] got_i = '0;
    logic el = 1'b0, ei = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    lsu_dir = 1'b0; lsu_addr = BASE; lsu_width = 4'd8; lsu_valid = 1'b1;
    ifu_addr = BASE + 64'h14; ifu_valid = 1'b1;
    while ((t_l < 0 || t_i < 0) && n < 60) begin
      @(posedge clk); #1; n++;
      if (!dropped && !o_ready) begin lsu_valid = 1'b0; dropped = 1'b1; end
      if (o_lvalid) begin t_l = n; got_l = o_ldata; el = o_err; end
      if (o_ivalid) begin t_i = n; got_i = o_idata; ei = o_err; ifu_valid = 1'b0; end
    end
    lsu_valid = 1'b0; ifu_valid = 1'b0;
    n_vec++;
    if (t_l < 2 || t_l > 2 + EXTRA || got_l !== exp_l || el !== 1'b0) begin
      n_bad++; $display("FAIL arb_lsu: resp edge=%0d data=%h err=%b, required edge 2..%0d data %h err 0",
                        t_l, got_l, el, 2 + EXTRA, exp_l);
    end
    n_vec++;
    if (t_i - t_l < 2 || t_i - t_l > 2 + EXTRA || got_i !== 32'h11223344 || ei !== 1'b0) begin
      n_bad++; $display("FAIL arb_ifu: gap=%0d data=%h err=%b, required gap 2..%0d data 11223344 err 0",
                        t_i - t_l, got_i, ei, 2 + EXTRA);
    end
  endtask

  task automatic test_errors();
    int lat; logic [63:0] rd, exp0; logic [31:0] ird; logic er;
    sel = 1'b0;
    exp0 = mdl_read(BASE, 8);
    do_lsu(1'b0, 64'h7FFF_FFF8, 8, 64'd0, lat, rd, er);
    n_vec++;
    if (er !== 1'b1 || rd !== 64'd0 || lat > 1 + EXTRA) begin
      n_bad++; $display("FAIL err_below: err=%b data=%h lat=%0d, required err 1 data 0", er, rd, lat);
    end
    do_lsu(1'b1, 64'h8000_0006, 4, 64'h0000_0000_DEAD_BEEF, lat, rd, er);
    n_vec++;
    if (er !== 1'b1 || lat > 1 + EXTRA) begin
      n_bad++; $display("FAIL err_cross_wr: err=%b lat=%0d, required err 1", er, lat);
    end
    do_lsu(1'b0, BASE, 8, 64'd0, lat, rd, er);
    n_vec++;
    if (er !== 1'b0 || rd !== exp0) begin
      n_bad++; $display("FAIL err_unchanged: err=%b data=%h, required 0 / %h", er, rd, exp0);
    end
    do_lsu(1'b0, BASE + 64'(DEPTH) * 8, 1, 64'd0, lat, rd, er);
    n_vec++;
    if (er !== 1'b1 || rd !== 64'd0) begin
      n_bad++; $display("FAIL err_above: err=%b data=%h, required 1 / 0", er, rd);
    end
    do_lsu(1'b0, BASE + 64'h8, 3, 64'd0, lat, rd, er);
    n_vec++;
    if (er !== 1'b1 || rd !== 64'd0) begin
      n_bad++; $display("FAIL err_width3: err=%b data=%h, required 1 / 0", er, rd);
    end
    do_ifu(BASE + 64'h2, lat, ird, er);
    n_vec++;
    if (er !== 1'b1 || ird !== 32'd0) begin
      n_bad++; $display("FAIL err_ifu_align: err=%b data=%h, required 1 / 0", er, ird);
    end
  endtask

  task automatic test_reset_mid();
    int lat, n = 0, pulses = 0; logic [63:0] rd; logic er;
    sel = 1'b1;
    do_lsu(1'b1, 64'h8000_0020, 8, 64'hCAFE_F00D_0123_4567, lat, rd, er);
    n_vec++;
    if (lat < 3 || lat > 3 + EXTRA || er !== 1'b0) begin
      n_bad++; $display("FAIL l3_wr: lat=%0d err=%b, required lat 3..%0d err 0", lat, er, 3 + EXTRA);
    end
    @(negedge clk);
    lsu_dir = 1'b1; lsu_addr = 64'h8000_0020; lsu_width = 4'd8; lsu_data = 64'h5555_AAAA_5555_AAAA; lsu_valid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (o_ready && n < 50);
    lsu_valid = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_b = 1'b1;
      if (o_lvalid || o_ivalid) pulses++;
    end
    n_vec++;
    if (pulses !== 0 || o_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid: pulses=%0d ready=%b, required 0 pulses ready 1", pulses, o_ready);
    end
    do_lsu(1'b0, 64'h8000_0020, 8, 64'd0, lat, rd, er);
    n_vec++;
    if (rd !== 64'hCAFE_F00D_0123_4567 || er !== 1'b0 || lat < 3 || lat > 3 + EXTRA) begin
      n_bad++; $display("FAIL reset_mid_rd: data=%h err=%b lat=%0d, required cafef00d01234567 err 0 lat 3..%0d",
                        rd, er, lat, 3 + EXTRA);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int lat, w, r, kind;
    int widths[6] = '{1, 2, 4, 8, 8, 3};
    logic [63:0] a, d, rd, exp_d; logic [31:0] ird; logic er, exp_e;
    sel = 1'b0;
    for (int k = 0; k < 200; k++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      a = BASE - 64'($urandom_range(1, 64));
      else if (r == 1) a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 63));
      else             a = BASE + 64'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 9));
      if (kind < 3) begin
        if ($urandom_range(0, 7) != 0) a = a & ~64'h3;
        exp_e = mdl_err(1'b1, a, 4);
        exp_d = exp_e ? 64'd0 : mdl_read(a, 4);
        do_ifu(a, lat, ird, er);
        n_vec++;
        if (lat < 1 || lat > 1 + EXTRA || er !== exp_e || ird !== exp_d[31:0]) begin
          n_bad++; $display("FAIL rnd_ifu[%0d] a=%h: lat=%0d err=%b data=%h, required err %b data %h",
                            k, a, lat, er, ird, exp_e, exp_d[31:0]);
        end
      end else begin
        w = widths[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) != 0) a = a & ~64'(w > 0 ? w - 1 : 0);
        exp_e = mdl_err(1'b0, a, w);
        d = {$urandom, $urandom};
        if (kind < 6) begin
          do_lsu(1'b1, a, w, d, lat, rd, er);
          if (!exp_e) mdl_write(a, w, d);
          n_vec++;
          if (lat < 1 || lat > 1 + EXTRA || er !== exp_e) begin
            n_bad++; $display("FAIL rnd_wr[%0d] a=%h w=%0d: lat=%0d err=%b, required err %b", k, a, w, lat, er, exp_e);
          end
        end else begin
          exp_d = exp_e ? 64'd0 : mdl_read(a, w);
          do_lsu(1'b0, a, w, 64'd0, lat, rd, er);
          n_vec++;
          if (lat < 1 || lat > 1 + EXTRA || er !== exp_e || rd !== exp_d) begin
            n_bad++; $display("FAIL rnd_rd[%0d] a=%h w=%0d: lat=%0d err=%b data=%h, required err %b data %h",
                              k, a, w, lat, er, rd, exp_e, exp_d);
          end
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
    lsu_valid = 1'b0; ifu_valid = 1'b0; lsu_dir = 1'b0;
    lsu_addr = '0; lsu_width = '0; lsu_data = '0; ifu_addr = '0;
    repeat (3) @(negedge clk);
    test_reset("reset_held");
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    test_reset("reset_release");
    test_fill();
    test_basic();
    test_partial();
    test_arbitration();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
